// File: rtl/alu4_reg.sv
// rtl/alu4_reg.sv - 4-bit ADD/SUB/AND/OR unit with registered result and carry/borrow flag
module alu4_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] S,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic       C0,
  output logic [3:0] C
);

  logic       is_sub;
  logic [3:0] b_op;
  logic [4:0] carry;
  logic [3:0] sum;
  logic [4:0] next_q;

  // SUB reuses the adder as A + ~B + 1; borrow is the inverted carry-out
  always_comb begin
    is_sub   = (S == 2'b01);
    b_op     = is_sub ? ~B : B;
    carry    = '0;
    sum      = '0;
    carry[0] = is_sub;
    for (int i = 0; i < 4; i++) begin
      sum[i]       = A[i] ^ b_op[i] ^ carry[i];
      carry[i + 1] = (A[i] & b_op[i]) | (carry[i] & (A[i] ^ b_op[i]));
    end
  end

  always_comb begin
    next_q = '0;
    case (S)
      2'b00: next_q = {carry[4], sum};
      2'b01: next_q = {~carry[4], sum};
      2'b10: next_q = {1'b0, A & B};
      2'b11: next_q = {1'b0, A | B};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      C0 <= 1'b0;
      C  <= 4'h0;
    end else begin
      C0 <= next_q[4];
      C  <= next_q[3:0];
    end
  end

endmodule

// File: tb/tb_alu4_reg.sv
// tb/tb_alu4_reg.sv - table-driven and scoreboard bench for alu4_reg
module tb_alu4_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] S;
  logic [3:0] A;
  logic [3:0] B;
  logic       C0;
  logic [3:0] C;

  int total = 0;
  int bad   = 0;
  logic [4:0] sb[$];

  alu4_reg dut (
    .clk(clk), .rst(rst), .S(S), .A(A), .B(B), .C0(C0), .C(C)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [1:0] s;
    logic [3:0] a;
    logic [3:0] b;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[9];

  function automatic logic [4:0] model(input logic [1:0] s, input logic [3:0] a, input logic [3:0] b);
    int r;
    case (s)
      2'b00: begin r = int'(a) + int'(b); return {r > 15, 4'(r % 16)}; end
      2'b01: begin r = int'(a) - int'(b); return {r < 0, 4'((r + 16) % 16)}; end
      2'b10: return {1'b0, a & b};
      default: return {1'b0, a | b};
    endcase
  endfunction

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got C0=%b C=%h, want C0=%b C=%h", name, act[4], act[3:0], exp[4], exp[3:0]);
    end
  endtask

  // drive at negedge, expectation queued, compared just after the capturing edge
  task automatic run_op(input string name, input logic [1:0] s, input logic [3:0] a,
                        input logic [3:0] b, input logic [4:0] exp);
    logic [4:0] e;
    @(negedge clk);
    S = s; A = a; B = b;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check(name, {C0, C}, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"add_f_1",  2'b00, 4'hF, 4'h1, 5'h10};
    vecs[1] = '{"add_f_f",  2'b00, 4'hF, 4'hF, 5'h1E};
    vecs[2] = '{"add_0_0",  2'b00, 4'h0, 4'h0, 5'h00};
    vecs[3] = '{"sub_0_1",  2'b01, 4'h0, 4'h1, 5'h1F};
    vecs[4] = '{"sub_9_4",  2'b01, 4'h9, 4'h4, 5'h05};
    vecs[5] = '{"sub_6_6",  2'b01, 4'h6, 4'h6, 5'h00};
    vecs[6] = '{"and_c_a",  2'b10, 4'hC, 4'hA, 5'h08};
    vecs[7] = '{"or_c_a",   2'b11, 4'hC, 4'hA, 5'h0E};
    vecs[8] = '{"add_7_3",  2'b00, 4'h7, 4'h3, 5'h0A};

    rst = 1'b1; S = 2'b00; A = 4'h7; B = 4'h3;
    @(posedge clk); #2;
    check("reset_hold", {C0, C}, 5'h00);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("first_after_reset", {C0, C}, 5'h0A);

    foreach (vecs[i]) run_op(vecs[i].name, vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].exp);

    // outputs hold while inputs change between edges
    run_op("hold_setup", 2'b00, 4'hF, 4'hF, 5'h1E);
    S = 2'b10; A = 4'h3; B = 4'h5;
    #2;
    check("hold_between_edges", {C0, C}, 5'h1E);
    @(posedge clk); #1;
    check("hold_then_update", {C0, C}, 5'h01);

    // asynchronous reset mid-cycle discards the pending operation
    run_op("pre_async", 2'b01, 4'h0, 4'h1, 5'h1F);
    S = 2'b00; A = 4'h9; B = 4'h9;
    #2;
    rst = 1'b1;
    #1;
    check("async_clear", {C0, C}, 5'h00);
    @(posedge clk); #1;
    check("reset_over_edge", {C0, C}, 5'h00);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("after_async_release", {C0, C}, 5'h12);

    for (int s = 0; s < 4; s++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          run_op($sformatf("sweep_s%0d_a%0h_b%0h", s, a, b), 2'(s), 4'(a), 4'(b),
                 model(2'(s), 4'(a), 4'(b)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu4_reg.md
Name: alu4_reg

Overview:
- 4-bit, four-function arithmetic/logic unit with a registered result and carry/borrow flag.
- Operands A and B are combined according to the 2-bit select S; the result is captured on the next rising clock edge.
- Used as the datapath execution element for small 4-bit designs and exercised exhaustively: 16 x 16 operands x 4 ops.

Parameters:
- None. Width is fixed at 4 bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- S    input  2  operation select
- A    input  4  operand A, unsigned
- B    input  4  operand B, unsigned
- C0   output 1  carry (ADD) / borrow (SUB) flag, registered
- C    output 4  result, registered

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset:
  - While rst=1, C=4'h0 and C0=0 immediately, independent of clk.
  - The first update after deassertion occurs on the next rising clk edge.
- Latency:
  - Exactly 1 cycle. S/A/B sampled at rising edge n appear on C/C0 after edge n.
  - No handshake; a new operation is accepted every cycle.
  - Outputs hold between edges even if inputs change.
- Operation select (next-state values):
  - S=2'b00 ADD: {C0,C} = A + B (5-bit unsigned sum); C0 is the carry-out of bit 3.
  - S=2'b01 SUB: C = (A - B) mod 16; C0 = 1 when A < B (borrow), else 0.
  - S=2'b10 AND: C = A & B; C0 = 0.
  - S=2'b11 OR: C = A | B; C0 = 0.
- Arithmetic:
  - Operands are unsigned 4-bit; no sign or overflow flag is produced.
  - ADD wraps modulo 16 with C0 capturing bit 4.
  - SUB wraps modulo 16 (two's complement), e.g. 0-1 gives C=4'hF, C0=1.
- Boundaries:
  - 15+15 gives C=4'hE, C0=1.
  - 15+1 gives C=4'h0, C0=1.
  - 0+0 gives C=0, C0=0.
  - A==B under SUB gives C=0, C0=0.
- Reset mid-operation: asserting rst between edges clears outputs at once; the pending operation is discarded.
- X/unknown S: not required to be handled; all four encodings are defined, so there is no default case beyond them.
- Implementation structure:
  - Combinational next-state logic feeding a 5-bit register (C0 plus C).
  - Adder/subtractor may be a ripple-carry chain, with SUB implemented as A + ~B + 1 and the borrow taken as the inverted carry-out.

Test Plan:
- Reset: rst=1 asynchronously with A=4'h7, B=4'h3, S=00 -> C=0, C0=0 immediately. Deassert, then one edge -> C=4'hA, C0=0.
- ADD carry: A=4'hF, B=4'h1, S=00, one edge -> C=4'h0, C0=1. A=4'hF, B=4'hF -> C=4'hE, C0=1.
- SUB borrow: A=4'h0, B=4'h1, S=01 -> C=4'hF, C0=1. A=4'h9, B=4'h4 -> C=4'h5, C0=0. A=B=4'h6 -> C=0, C0=0.
- Logic: A=4'hC, B=4'hA, S=10 -> C=4'h8, C0=0. Same operands, S=11 -> C=4'hE, C0=0.
- Latency/hold: change A/B/S between edges -> C/C0 unchanged until the next rising edge, then reflect the new values.
- Exhaustive sweep: all 16x16x4 combinations, one per cycle, compared against a golden model -> zero mismatches.
